// File: rtl/mips_muldiv_pkg.sv
// Shared types and constants for the HI/LO multiply/divide sequencer.
// Divider support is compiled in only when MULDIV_DIV_EN is defined.
package mips_muldiv_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX
  } md_state_t;

  localparam int unsigned MD_ITER = 32;

`ifdef MULDIV_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

endpackage

// File: rtl/mips_muldiv_step.sv
// One radix-2 iteration: shift-add multiply (mode=0) or restoring divide (mode=1).
// acc holds {upper, lower}: product/multiplier for multiply, remainder/quotient for divide.
module mips_muldiv_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   operand,
  input  logic               mode,
  output logic [2*WIDTH-1:0] acc_next
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   rem;
  logic [WIDTH-1:0] diff;
  logic             ge;

  always_comb begin
    sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
    // Shifted partial remainder needs one extra bit before the trial subtract.
    rem  = acc[2*WIDTH-1:WIDTH-1];
    ge   = (rem >= {1'b0, operand});
    diff = rem[WIDTH-1:0] - operand;
    if (mode) begin
      if (ge) begin
        acc_next = {diff, acc[WIDTH-2:0], 1'b1};
      end else begin
        acc_next = {rem[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_next = {sum, acc[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mips_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO; 33-cycle latency.
// Define MULDIV_DIV_EN to enable DIV/DIVU; otherwise divide issues are ignored.
module mips_muldiv #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned MD_ITER = WIDTH
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             md_start,
  input  logic [1:0]       md_op,
  input  logic [WIDTH-1:0] md_rs,
  input  logic [WIDTH-1:0] md_rt,
  input  logic             md_hi_we,
  input  logic             md_lo_we,
  input  logic [WIDTH-1:0] md_wdata,
  input  logic             md_rd_req,
  input  logic             md_kill,
  output logic             md_busy,
  output logic             md_stall,
  output logic [WIDTH-1:0] md_hi,
  output logic [WIDTH-1:0] md_lo,
  output logic             md_div0
);
  import mips_muldiv_pkg::*;

  localparam int unsigned CntW = $clog2(MD_ITER);

  md_state_t          state_q, state_d;
  logic [CntW-1:0]    cnt_q;
  logic [2*WIDTH-1:0] acc_q, acc_step, prod;
  logic [WIDTH-1:0]   opnd_q, hi_q, lo_q, fix_hi, fix_lo;
  logic               is_div_q, neg_hi_q, neg_lo_q, div0_q, div0_pulse_q;

  md_op_t           op;
  logic             op_signed, op_div, rs_neg, rt_neg, accept;
  logic [WIDTH-1:0] rs_mag, rt_mag;

  assign op        = md_op_t'(md_op);
  assign op_signed = (op == MD_MULT) || (op == MD_DIV);
  assign op_div    = (op == MD_DIV) || (op == MD_DIVU);
  assign rs_neg    = op_signed & md_rs[WIDTH-1];
  assign rt_neg    = op_signed & md_rt[WIDTH-1];
  assign rs_mag    = rs_neg ? -md_rs : md_rs;
  assign rt_mag    = rt_neg ? -md_rt : md_rt;
  assign accept    = (state_q == IDLE) & md_start & ~md_kill & (DIV_EN | ~op_div);

  mips_muldiv_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .acc      (acc_q),
    .operand  (opnd_q),
    .mode     (is_div_q),
    .acc_next (acc_step)
  );

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN:     if (cnt_q == '0) state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (md_kill) state_d = IDLE;
  end

  always_comb begin
    md_busy  = (state_q != IDLE);
    md_stall = md_busy & (md_start | md_rd_req | md_hi_we | md_lo_we);
  end

  // Sign correction applied in FIX; a zero divisor forces LO to all ones.
  always_comb begin
    prod   = neg_lo_q ? -acc_q : acc_q;
    fix_hi = prod[2*WIDTH-1:WIDTH];
    fix_lo = prod[WIDTH-1:0];
    if (is_div_q) begin
      fix_lo = div0_q ? '1 : (neg_lo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]);
      fix_hi = neg_hi_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      cnt_q        <= '0;
      acc_q        <= '0;
      opnd_q       <= '0;
      is_div_q     <= 1'b0;
      neg_hi_q     <= 1'b0;
      neg_lo_q     <= 1'b0;
      div0_q       <= 1'b0;
      div0_pulse_q <= 1'b0;
      hi_q         <= '0;
      lo_q         <= '0;
    end else begin
      div0_pulse_q <= 1'b0;
      if (accept) begin
        cnt_q    <= CntW'(MD_ITER - 1);
        acc_q    <= {{WIDTH{1'b0}}, op_div ? rs_mag : rt_mag};
        opnd_q   <= op_div ? rt_mag : rs_mag;
        is_div_q <= op_div;
        neg_lo_q <= rs_neg ^ rt_neg;
        neg_hi_q <= op_div ? rs_neg : (rs_neg ^ rt_neg);
        div0_q   <= op_div & (md_rt == '0);
      end else if (state_q == RUN && !md_kill) begin
        acc_q <= acc_step;
        if (cnt_q != '0) cnt_q <= cnt_q - CntW'(1);
      end else if (state_q == FIX && !md_kill) begin
        hi_q         <= fix_hi;
        lo_q         <= fix_lo;
        div0_pulse_q <= div0_q;
      end else if (state_q == IDLE && !md_start) begin
        // MTHI/MTLO only land while idle and not colliding with an issue.
        if (md_hi_we) hi_q <= md_wdata;
        if (md_lo_we) lo_q <= md_wdata;
      end
    end
  end

  assign md_hi   = hi_q;
  assign md_lo   = lo_q;
  assign md_div0 = div0_pulse_q;

endmodule

// File: tb/tb_mips_muldiv.sv
// Self-checking bench for mips_muldiv: directed cases plus random traffic against
// a cycle-count/arithmetic reference model. Honors MULDIV_DIV_EN like the design.
module tb_mips_muldiv;

  logic        clk = 1'b0;
  logic        rst_b = 1'b1;
  logic        md_start = 1'b0;
  logic [1:0]  md_op = 2'b00;
  logic [31:0] md_rs = '0;
  logic [31:0] md_rt = '0;
  logic        md_hi_we = 1'b0;
  logic        md_lo_we = 1'b0;
  logic [31:0] md_wdata = '0;
  logic        md_rd_req = 1'b0;
  logic        md_kill = 1'b0;
  logic        md_busy, md_stall, md_div0;
  logic [31:0] md_hi, md_lo;

`ifdef MULDIV_DIV_EN
  localparam bit DivEn = 1'b1;
`else
  localparam bit DivEn = 1'b0;
`endif

  always #5 clk = ~clk;

  mips_muldiv #(
    .WIDTH   (32),
    .MD_ITER (32)
  ) dut (
    .clk       (clk),
    .rst_b     (rst_b),
    .md_start  (md_start),
    .md_op     (md_op),
    .md_rs     (md_rs),
    .md_rt     (md_rt),
    .md_hi_we  (md_hi_we),
    .md_lo_we  (md_lo_we),
    .md_wdata  (md_wdata),
    .md_rd_req (md_rd_req),
    .md_kill   (md_kill),
    .md_busy   (md_busy),
    .md_stall  (md_stall),
    .md_hi     (md_hi),
    .md_lo     (md_lo),
    .md_div0   (md_div0)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural result {div0, HI, LO} from plain arithmetic.
  function automatic logic [64:0] md_ref(input logic [1:0] op, input logic [31:0] rs,
                                         input logic [31:0] rt);
    longint      a, b;
    logic [63:0] p, q, r;
    a = longint'($signed(rs));
    b = longint'($signed(rt));
    q = '0;
    r = '0;
    case (op)
      2'b00: p = a * b;
      2'b01: p = {32'd0, rs} * {32'd0, rt};
      default: begin
        if (rt == 32'd0) begin
          p = {rs, 32'hFFFF_FFFF};
        end else begin
          if (op == 2'b10) begin
            q = a / b;
            r = a % b;
          end else begin
            q = {32'd0, rs} / {32'd0, rt};
            r = {32'd0, rs} % {32'd0, rt};
          end
          p = {r[31:0], q[31:0]};
        end
      end
    endcase
    return {op[1] && (rt == 32'd0), p};
  endfunction

  bit          m_busy = 1'b0;
  bit          m_div0 = 1'b0;
  bit [31:0]   m_hi = '0;
  bit [31:0]   m_lo = '0;
  int          m_cnt = 0;
  logic [64:0] p_res = '0;

  // Model: an accepted op completes 33 edges later unless killed.
  always @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      m_busy <= 1'b0;
      m_cnt  <= 0;
      m_hi   <= '0;
      m_lo   <= '0;
      m_div0 <= 1'b0;
    end else begin
      m_div0 <= 1'b0;
      if (m_busy) begin
        if (md_kill) begin
          m_busy <= 1'b0;
        end else if (m_cnt == 1) begin
          m_busy <= 1'b0;
          m_div0 <= p_res[64];
          m_hi   <= p_res[63:32];
          m_lo   <= p_res[31:0];
        end else begin
          m_cnt <= m_cnt - 1;
        end
      end else if (md_start) begin
        if (!md_kill && (DivEn || !md_op[1])) begin
          m_busy <= 1'b1;
          m_cnt  <= 33;
          p_res  <= md_ref(md_op, md_rs, md_rt);
        end
      end else begin
        if (md_hi_we) m_hi <= md_wdata;
        if (md_lo_we) m_lo <= md_wdata;
      end
    end
  end

  always @(negedge clk) begin
    chk("busy", 64'(md_busy), 64'(m_busy));
    chk("stall", 64'(md_stall), 64'(m_busy & (md_start | md_rd_req | md_hi_we | md_lo_we)));
    chk("hi", 64'(md_hi), 64'(m_hi));
    chk("lo", 64'(md_lo), 64'(m_lo));
    chk("div0", 64'(md_div0), 64'(m_div0));
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Issue one op at the next edge and count the cycles md_busy stays high.
  task automatic run_op(input logic [1:0] op, input logic [31:0] rs, input logic [31:0] rt,
                        output int n);
    md_start = 1'b1;
    md_op    = op;
    md_rs    = rs;
    md_rt    = rt;
    cyc();
    md_start = 1'b0;
    n = 0;
    while (md_busy && n < 100) begin
      n++;
      cyc();
    end
    if (n >= 100) chk("op_timeout", 64'(n), 64'd33);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish, time %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int sel;
    #1 rst_b = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_b = 1'b1;
    @(negedge clk);
    chk("reset_hi", 64'(md_hi), 64'd0);
    chk("reset_lo", 64'(md_lo), 64'd0);
    chk("reset_busy", 64'(md_busy), 64'd0);
    cyc();

    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, n);
    chk("multu_latency", 64'(n), 64'd33);
    chk("multu_hi", 64'(md_hi), 64'hFFFF_FFFE);
    chk("multu_lo", 64'(md_lo), 64'h0000_0001);

    run_op(2'b00, 32'hFFFF_FFFD, 32'd7, n);
    chk("mult_hi", 64'(md_hi), 64'hFFFF_FFFF);
    chk("mult_lo", 64'(md_lo), 64'hFFFF_FFEB);

`ifdef MULDIV_DIV_EN
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, n);
    chk("div_lo", 64'(md_lo), 64'hFFFF_FFFD);
    chk("div_hi", 64'(md_hi), 64'hFFFF_FFFF);

    run_op(2'b11, 32'd7, 32'd0, n);
    chk("div0_latency", 64'(n), 64'd33);
    chk("div0_hi", 64'(md_hi), 64'd7);
    chk("div0_lo", 64'(md_lo), 64'hFFFF_FFFF);
    chk("div0_pulse", 64'(md_div0), 64'd1);
    cyc();
    chk("div0_pulse_end", 64'(md_div0), 64'd0);

    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, n);
    chk("div_ovf_lo", 64'(md_lo), 64'h8000_0000);
    chk("div_ovf_hi", 64'(md_hi), 64'd0);
`else
    run_op(2'b11, 32'd9, 32'd3, n);
    chk("divu_off_busy", 64'(n), 64'd0);
    chk("divu_off_hi", 64'(md_hi), 64'hFFFF_FFFF);
    chk("divu_off_lo", 64'(md_lo), 64'hFFFF_FFEB);
    run_op(2'b01, 32'd9, 32'd3, n);
    chk("multu_off_lo", 64'(md_lo), 64'd27);
`endif

    // MFHI and MTHI held across a MULTU: stalled until completion.
    md_start = 1'b1;
    md_op    = 2'b01;
    md_rs    = 32'd5;
    md_rt    = 32'd6;
    cyc();
    md_start  = 1'b0;
    md_rd_req = 1'b1;
    md_hi_we  = 1'b1;
    md_wdata  = 32'h1234;
    n = 0;
    while (md_stall && n < 100) begin
      n++;
      cyc();
    end
    chk("stall_cycles", 64'(n), 64'd33);
    chk("stall_new_lo", 64'(md_lo), 64'd30);
    chk("stall_new_hi", 64'(md_hi), 64'd0);
    cyc();
    chk("mthi_applied", 64'(md_hi), 64'h1234);
    md_rd_req = 1'b0;
    md_hi_we  = 1'b0;

    md_hi_we = 1'b1;
    md_wdata = 32'hA;
    cyc();
    md_hi_we = 1'b0;
    md_lo_we = 1'b1;
    md_wdata = 32'hB;
    cyc();
    md_lo_we = 1'b0;
    md_start = 1'b1;
    md_op    = 2'b00;
    md_rs    = 32'd100;
    md_rt    = 32'd200;
    cyc();
    md_start = 1'b0;
    repeat (9) cyc();
    md_kill = 1'b1;
    cyc();
    md_kill = 1'b0;
    chk("kill_busy", 64'(md_busy), 64'd0);
    chk("kill_hi", 64'(md_hi), 64'hA);
    chk("kill_lo", 64'(md_lo), 64'hB);

    for (int i = 0; i < 3000; i++) begin
      sel       = int'($urandom_range(7));
      md_start  = ($urandom_range(19) == 0);
      md_op     = 2'($urandom_range(3));
      md_rs     = (sel == 0) ? 32'h8000_0000 : (sel == 1) ? 32'($urandom_range(20)) : $urandom;
      md_rt     = (sel == 0) ? 32'hFFFF_FFFF : (sel == 2) ? 32'd0 :
                  (sel == 3) ? 32'($urandom_range(5)) : $urandom;
      md_rd_req = ($urandom_range(3) == 0);
      md_hi_we  = ($urandom_range(7) == 0);
      md_lo_we  = ($urandom_range(7) == 0);
      md_wdata  = $urandom;
      md_kill   = ($urandom_range(99) == 0);
      cyc();
    end
    md_kill   = 1'b0;
    md_rd_req = 1'b0;
    md_hi_we  = 1'b0;
    md_lo_we  = 1'b0;

    // Reset in the middle of an op clears everything.
    md_start = 1'b1;
    md_op    = 2'b01;
    md_rs    = 32'd3;
    md_rt    = 32'd4;
    cyc();
    md_start = 1'b0;
    repeat (5) cyc();
    rst_b = 1'b0;
    @(negedge clk);
    chk("rst_mid_busy", 64'(md_busy), 64'd0);
    chk("rst_mid_hi", 64'(md_hi), 64'd0);
    chk("rst_mid_lo", 64'(md_lo), 64'd0);
    chk("rst_mid_stall", 64'(md_stall), 64'd0);
    cyc();
    rst_b = 1'b1;
    repeat (3) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_muldiv.md
# mips_muldiv

Iterative multiply/divide sequencer owning the HI/LO register pair for the 447 MIPS core. Accepts MULT/MULTU/DIV/DIVU issued by decode, runs a radix-2 shift-add / restoring-divide loop for 32 cycles, and applies sign correction in one cycle. Asserts a stall to the core when an instruction touches HI/LO or issues a new op while busy. Sits beside mips_ALU in execute; MFHI/MFLO results feed the register-file write mux.

## Interface
- WIDTH, 32, operand and HI/LO width; only 32 is supported.
- MD_ITER, WIDTH, iteration count.
- clk  in  1  clock, rising edge.
- rst_b  in  1  reset, asynchronous, active-low.
- md_start  in  1  op issue, one cycle, from decoder.
- md_op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- md_rs, md_rt  in  WIDTH  operands (rs = dividend/multiplicand).
- md_hi_we, md_lo_we  in  1  MTHI/MTLO write strobes.
- md_wdata  in  WIDTH  MTHI/MTLO data.
- md_rd_req  in  1  MFHI/MFLO in decode.
- md_kill  in  1  abort (exception/halt).
- md_busy  out  1  op in flight.
- md_stall  out  1  core must hold PC and instruction.
- md_hi, md_lo  out  WIDTH  architectural HI/LO.
- md_div0  out  1  one-cycle pulse: divide by zero completed.

## Operation
- States: IDLE, RUN, FIX. md_busy = (state != IDLE).
- IDLE & md_start: latch |rs|, |rt| (raw for unsigned ops), result-sign flags, op; counter = MD_ITER-1; -> RUN.
- RUN: one iteration per cycle; counter decrements; at 0 -> FIX.
- FIX: negate per flags, write HI/LO, -> IDLE.
- MULT/MULTU: {HI,LO} = 64-bit product; MULT negated if rs[31]^rt[31].
- DIV/DIVU: LO = quotient, HI = remainder; signed quotient sign = rs^rt, remainder sign = rs. 0x80000000 / -1 yields LO=0x80000000, HI=0 (no trap).
- Divisor 0: full latency; HI = md_rs as issued, LO = 32'hFFFFFFFF; md_div0 pulses on the FIX->IDLE edge.
- md_stall = md_busy & (md_start | md_rd_req | md_hi_we | md_lo_we); combinational.
- IDLE: md_hi_we/md_lo_we write md_wdata at the edge. md_start together with a write: start wins, write dropped.
- md_kill: any state -> IDLE next edge; HI/LO keep pre-op values; no md_div0. md_kill in IDLE has no effect; md_kill wins over md_start.
- md_start in RUN/FIX is ignored (stalled), not queued.

## Timing
- Reset: state IDLE, counter 0, md_hi = md_lo = 0, md_busy = 0, md_stall = 0, md_div0 = 0. Reset mid-op discards it.
- md_start sampled at edge E0; md_busy high from E0 through E33; HI/LO update and md_busy falls at E33. Latency 33 cycles.
- An MFHI stalled by the op reads the new HI in the cycle after E33.
- Back-to-back: a new md_start is accepted in the first cycle md_busy is low.
- md_hi/md_lo are register outputs; no combinational path from inputs.

## Configuration
- MULDIV_DIV_EN defined: full behaviour above.
- Undefined: no divider datapath. md_start with md_op[1]=1 is ignored: no state change, HI/LO unchanged. md_div0 is tied 0. MULT/MULTU unchanged.

## Structure
- Package mips_muldiv_pkg: md_op_t enum (MD_MULT, MD_MULTU, MD_DIV, MD_DIVU), md_state_t enum (IDLE, RUN, FIX), MD_ITER constant.
- Sub-module mips_muldiv_step: combinational single iteration. Input {acc, operand, mode}, output next acc. Shift-add for multiply, trial subtract/restore for divide.
- FSM, counter, sign flags and HI/LO registers live in mips_muldiv.

## Test plan
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001; md_busy exactly 33 cycles.
- MULT -3 x 7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB; then DIV -7 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU 7 / 0 -> HI=7, LO=0xFFFFFFFF, one md_div0 pulse at E33. DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- md_rd_req held from E1 -> md_stall high until E33, low after. MTHI 0x1234 while busy -> stalled; applied after completion.
- md_kill at cycle 10 of MULT with prior HI=0xA, LO=0xB -> IDLE next edge, HI/LO remain 0xA/0xB. rst_b low mid-op -> all outputs 0.
- MULTU_DIV_EN undefined: DIVU 9/3 -> md_busy stays 0, HI/LO unchanged; MULTU 9x3 -> LO=27.
